// File: rtl/fifo_defs_pkg.sv
// -----------------------------------------------------------------------------
// fifo_defs_pkg
// Shared definitions for the synchronous FIFO family: default geometry,
// default watermark levels, the pointer-width derivation and the packed
// status-flag record used by the FIFO top level. Benches and future FIFO
// variants import this package so that all of them agree on the defaults.
// -----------------------------------------------------------------------------
package fifo_defs_pkg;

  // Default geometry: 8-bit words, 16 entries.
  localparam int unsigned FIFO_DEF_DATA_W   = 8;
  localparam int unsigned FIFO_DEF_ADDR_W   = 4;

  // Default watermarks for a 16-deep FIFO.
  localparam int unsigned FIFO_DEF_AF_LEVEL = 12;
  localparam int unsigned FIFO_DEF_AE_LEVEL = 4;

  // Pointers carry one extra wrap bit above the RAM address so that a full
  // FIFO (same address, different lap) can be told apart from an empty one.
  function automatic int unsigned fifo_ptr_w(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  // Occupancy-derived status flags, registered together.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  // Status of an empty FIFO (also the reset value). almost_empty is set
  // because a count of 0 is always at or below any legal AE level.
  localparam fifo_status_t FIFO_STATUS_EMPTY = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1
  };

endpackage : fifo_defs_pkg

// File: rtl/sync_fifo_ram.sv
// -----------------------------------------------------------------------------
// sync_fifo_ram
// DEPTH x DATA_W simple dual-port storage for the synchronous FIFO.
// One write port, one synchronous read port, single clock. Read-during-write
// to the same address returns the old contents.
//
// Ports
//   clk      in   clock, rising edge
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable; rdata_o updates only when set
//   raddr_i  in   read address
//   rdata_o  out  registered read data, holds between reads
// -----------------------------------------------------------------------------
module sync_fifo_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: storage arrays carry no reset so they map onto RAM macros or
  // plain flops without a reset tree; the top level masks any stale output.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : sync_fifo_ram

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with registered occupancy count,
// programmable almost-full / almost-empty watermarks and sticky
// overflow / underflow error flags with an explicit clear.
// Read latency is one cycle: rd sampled at edge N gives data_out/rd_valid
// after edge N.
//
// Parameters
//   DATA_W    word width in bits
//   ADDR_W    log2 of depth; DEPTH = 2**ADDR_W
//   AF_LEVEL  almost_full  when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  almost_empty when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports
//   clk             in   clock, rising edge
//   rst             in   synchronous active-high reset
//   wr, data_in     in   write request and data
//   rd              in   read request
//   data_out        out  registered read data, holds when no read accepted
//   rd_valid        out  data_out carries the word of an accepted read
//   fifo_full       out  count == DEPTH
//   fifo_empty      out  count == 0
//   almost_full     out  count >= AF_LEVEL
//   almost_empty    out  count <= AE_LEVEL
//   count           out  occupancy 0..DEPTH
//   fifo_overflow   out  sticky: write rejected while full
//   fifo_underflow  out  sticky: read rejected while empty
//   err_clr         in   clears both sticky flags (a new error wins)
// -----------------------------------------------------------------------------
module sync_fifo_param
  import fifo_defs_pkg::*;
#(
  parameter int unsigned DATA_W   = FIFO_DEF_DATA_W,
  parameter int unsigned ADDR_W   = FIFO_DEF_ADDR_W,
  parameter int unsigned AF_LEVEL = FIFO_DEF_AF_LEVEL,
  parameter int unsigned AE_LEVEL = FIFO_DEF_AE_LEVEL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              fifo_overflow,
  output logic              fifo_underflow,
  input  logic              err_clr
);

  localparam int unsigned PTR_W = fifo_ptr_w(ADDR_W);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0] AF_CNT  = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_CNT  = PTR_W'(AE_LEVEL);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] wptr_q,  wptr_d;
  logic [PTR_W-1:0] rptr_q,  rptr_d;
  logic [PTR_W-1:0] count_q, count_d;
  fifo_status_t     status_q, status_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             rd_valid_q;
  // Set by the first accepted read after reset; until then data_out shows
  // zero instead of whatever the unreset RAM output register holds.
  logic             out_live_q;

  logic             wr_ok;
  logic             rd_ok;
  logic [DATA_W-1:0] ram_rdata;

  // ---------------------------------------------------------------------------
  // Accept logic
  // ---------------------------------------------------------------------------
  // Operations in a reset cycle are ignored, so they must not reach the RAM.
  // A write into a full FIFO is still accepted when a read frees a slot in the
  // same cycle: the RAM returns the old word at that address before the write
  // lands, so the read sees the oldest entry and the write reuses its slot.
  assign rd_ok = rd & ~rst & ~status_q.empty;
  assign wr_ok = wr & ~rst & (~status_q.full | rd_ok);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (wptr_q[ADDR_W-1:0]),
    .wdata_i (data_in),
    .re_i    (rd_ok),
    .raddr_i (rptr_q[ADDR_W-1:0]),
    .rdata_o (ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;

    if (wr_ok) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (rd_ok) begin
      rptr_d = rptr_q + PTR_ONE;
    end

    // Clear first, then let a same-cycle error event override it.
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr & ~wr_ok) begin
      ovf_d = 1'b1;
    end
    if (rd & ~rd_ok) begin
      unf_d = 1'b1;
    end

    // Count and flags are derived from the next pointers, so the registered
    // values reflect this edge's operations with no extra cycle of lag.
    count_d               = wptr_d - rptr_d;
    status_d.empty        = (wptr_d == rptr_d);
    status_d.full         = (wptr_d[ADDR_W-1:0] == rptr_d[ADDR_W-1:0]) &&
                            (wptr_d[ADDR_W] != rptr_d[ADDR_W]);
    status_d.almost_full  = (count_d >= AF_CNT);
    status_d.almost_empty = (count_d <= AE_CNT);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      status_q   <= FIFO_STATUS_EMPTY;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      out_live_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      status_q   <= status_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_valid_q <= rd_ok;
      if (rd_ok) begin
        out_live_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The RAM output register only loads on an accepted read, so data_out holds
  // its last value between reads.
  assign data_out       = out_live_q ? ram_rdata : '0;
  assign rd_valid       = rd_valid_q;
  assign count          = count_q;
  assign fifo_full      = status_q.full;
  assign fifo_empty     = status_q.empty;
  assign almost_full    = status_q.almost_full;
  assign almost_empty   = status_q.almost_empty;
  assign fifo_overflow  = ovf_q;
  assign fifo_underflow = unf_q;

endmodule : sync_fifo_param

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Directed bench for sync_fifo_param at default geometry (8 bits x 16).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the
// same point, i.e. just after the edge that registered them.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;
  import fifo_defs_pkg::*;

  localparam int unsigned DATA_W = FIFO_DEF_DATA_W;
  localparam int unsigned ADDR_W = FIFO_DEF_ADDR_W;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr;
  logic [DATA_W-1:0] data_in;
  logic              rd;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              fifo_full;
  logic              fifo_empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              fifo_overflow;
  logic              fifo_underflow;
  logic              err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] model_q[$];

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .AF_LEVEL (FIFO_DEF_AF_LEVEL),
    .AE_LEVEL (FIFO_DEF_AE_LEVEL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr             (wr),
    .data_in        (data_in),
    .rd             (rd),
    .data_out       (data_out),
    .rd_valid       (rd_valid),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .count          (count),
    .fifo_overflow  (fifo_overflow),
    .fifo_underflow (fifo_underflow),
    .err_clr        (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs already set, wait for the edge, settle, clear strobes.
  task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
    wr      = w;
    data_in = d;
    rd      = r;
    err_clr = c;
    @(posedge clk);
    #1;
    wr      = 1'b0;
    rd      = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " count"},     32'(count), 32'd0);
    check({tag, " empty"},     32'(fifo_empty), 32'd1);
    check({tag, " full"},      32'(fifo_full), 32'd0);
    check({tag, " ae"},        32'(almost_empty), 32'd1);
    check({tag, " af"},        32'(almost_full), 32'd0);
    check({tag, " rd_valid"},  32'(rd_valid), 32'd0);
    check({tag, " data_out"},  32'(data_out), 32'd0);
    check({tag, " overflow"},  32'(fifo_overflow), 32'd0);
    check({tag, " underflow"}, 32'(fifo_underflow), 32'd0);
  endtask

  initial begin
    logic              w, r, exp_rd;
    logic [DATA_W-1:0] d, exp_d;

    rst = 1'b1; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; data_in = '0;
    @(posedge clk); #1;
    // Requests during reset must be ignored.
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    rst = 1'b0;
    check_reset_state("reset");

    // Fill with 0x01..0x10.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, DATA_W'(i), 1'b0, 1'b0);
      check($sformatf("fill%0d count", i), 32'(count), 32'(i));
      check($sformatf("fill%0d af", i),    32'(almost_full), 32'(i >= 12));
      check($sformatf("fill%0d full", i),  32'(fifo_full), 32'(i == 16));
      check($sformatf("fill%0d ae", i),    32'(almost_empty), 32'(i <= 4));
      check($sformatf("fill%0d ovf", i),   32'(fifo_overflow), 32'd0);
    end

    // 17th write while full is rejected.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    check("ovf17 overflow", 32'(fifo_overflow), 32'd1);
    check("ovf17 count",    32'(count), 32'd16);

    // Drain: 0x01..0x10 in order, 0x11 never stored.
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check($sformatf("drain%0d valid", i), 32'(rd_valid), 32'd1);
      check($sformatf("drain%0d data", i),  32'(data_out), 32'(i));
      check($sformatf("drain%0d count", i), 32'(count), 32'(16 - i));
      check($sformatf("drain%0d empty", i), 32'(fifo_empty), 32'(i == 16));
      check($sformatf("drain%0d ae", i),    32'(almost_empty), 32'(16 - i <= 4));
    end

    // Read while empty.
    step(1'b0, '0, 1'b1, 1'b0);
    check("unf underflow", 32'(fifo_underflow), 32'd1);
    check("unf rd_valid",  32'(rd_valid), 32'd0);
    check("unf data_hold", 32'(data_out), 32'h10);
    check("unf overflow",  32'(fifo_overflow), 32'd1);

    step(1'b0, '0, 1'b0, 1'b1);
    check("clr overflow",  32'(fifo_overflow), 32'd0);
    check("clr underflow", 32'(fifo_underflow), 32'd0);

    // Clear and new underflow in the same cycle: the event wins.
    step(1'b0, '0, 1'b1, 1'b1);
    check("clr+unf underflow", 32'(fifo_underflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("clr2 underflow", 32'(fifo_underflow), 32'd0);

    // Full plus simultaneous write/read.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, DATA_W'(8'hB0 + i), 1'b0, 1'b0);
    end
    check("full2 full", 32'(fifo_full), 32'd1);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    check("fullwr count",    32'(count), 32'd16);
    check("fullwr overflow", 32'(fifo_overflow), 32'd0);
    check("fullwr valid",    32'(rd_valid), 32'd1);
    check("fullwr data",     32'(data_out), 32'hB0);
    check("fullwr full",     32'(fifo_full), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check($sformatf("drain2_%0d data", i), 32'(data_out), (i == 16) ? 32'hAA : 32'(8'hB0 + i));
    end
    check("drain2 empty", 32'(fifo_empty), 32'd1);

    // Empty plus simultaneous write/read: no bypass.
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("emptywr count",     32'(count), 32'd1);
    check("emptywr underflow", 32'(fifo_underflow), 32'd1);
    check("emptywr valid",     32'(rd_valid), 32'd0);
    step(1'b0, '0, 1'b1, 1'b1);
    check("emptywr rd data",  32'(data_out), 32'h55);
    check("emptywr rd valid", 32'(rd_valid), 32'd1);
    check("emptywr cleared",  32'(fifo_underflow), 32'd0);

    // 40 random interleaved operations against a reference queue.
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = DATA_W'($urandom);
      exp_rd = r && (model_q.size() > 0);
      exp_d  = exp_rd ? model_q[0] : '0;
      step(w, d, r, 1'b0);
      if (exp_rd) begin
        void'(model_q.pop_front());
      end
      if (w && (model_q.size() < DEPTH || exp_rd)) begin
        model_q.push_back(d);
      end
      check($sformatf("rand%0d valid", i), 32'(rd_valid), 32'(exp_rd));
      if (exp_rd) begin
        check($sformatf("rand%0d data", i), 32'(data_out), 32'(exp_d));
      end
      check($sformatf("rand%0d count", i), 32'(count), 32'(model_q.size()));
      // Random idle gap of 0..2 cycles.
      repeat ($urandom_range(0, 2)) step(1'b0, '0, 1'b0, 1'b0);
    end

    // Bring occupancy to 7, then reset mid-operation.
    for (int i = 0; i < 2 * DEPTH && model_q.size() < 7; i++) begin
      d = DATA_W'(8'hC0 + i);
      step(1'b1, d, 1'b0, 1'b0);
      model_q.push_back(d);
    end
    for (int i = 0; i < 2 * DEPTH && model_q.size() > 7; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      void'(model_q.pop_front());
    end
    check("pre-rst count", 32'(count), 32'd7);
    step(1'b1, 8'h99, 1'b1, 1'b1);
    check("pre-rst valid", 32'(rd_valid), 32'd1);
    rst = 1'b1;
    step(1'b1, 8'h77, 1'b1, 1'b0);
    rst = 1'b0;
    model_q.delete();
    check_reset_state("midrst");

    step(1'b1, 8'h3C, 1'b0, 1'b0);
    check("post-rst wr count", 32'(count), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("post-rst rd data",  32'(data_out), 32'h3C);
    check("post-rst rd valid", 32'(rd_valid), 32'd1);
    check("post-rst empty",    32'(fifo_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sync_fifo_param
